// File: rtl/sd_pkg.sv
// Shared definitions for the SD card block buffer: CRC16 polynomial and
// byte-step function, default block size, data token, FSM state encoding.
package sd_pkg;

    localparam logic [15:0] CRC16_POLY          = 16'h1021;
    localparam int          DEFAULT_BLOCK_BYTES = 512;
    localparam logic [7:0]  DATA_TOKEN          = 8'hFE;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        CRC_HI = 3'd2,
        CRC_LO = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Advance a CRC16-CCITT (MSB first) accumulator by one whole byte.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc_in,
                                               input logic [7:0]  data);
        logic [15:0] c;
        c = crc_in ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ({c[14:0], 1'b0} ^ CRC16_POLY) : {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/sd_block_ram.sv
// Single-clock block RAM: one synchronous write port, one registered read
// port with read-before-write behaviour on address collisions.
module sd_block_ram #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [DEPTH];

    // Write port.
    // NOTE: the array is deliberately not reset so it maps onto block RAM;
    // only the read register below is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port.
    // NOTE: non-blocking assignments make a same-cycle read of the address
    // being written return the previous contents (read-before-write).
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= 8'h00;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sd_block_buffer.sv
// Captures one SD data block (BLOCK_BYTES data bytes plus a 16-bit CRC)
// into a RAM, checks the CRC and exposes the bytes on a registered read port.
module sd_block_buffer
    import sd_pkg::*;
#(
    parameter int BLOCK_BYTES = DEFAULT_BLOCK_BYTES,
    parameter int ADDR_W      = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              busy,
    output logic              block_ready,
    output logic              crc_ok,
    output logic [ADDR_W:0]   byte_count
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(BLOCK_BYTES);
    localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W+1)'(BLOCK_BYTES - 1);
    localparam logic [ADDR_W:0] ONE        = (ADDR_W+1)'(1);

    state_t      state;
    logic [15:0] crc;
    logic [7:0]  crc_rx_hi;
    logic        wr_en;

    // Data bytes are written only while capturing the data phase.
    assign wr_en = (state == DATA) && byte_valid;

    sd_block_ram #(
        .DEPTH  (BLOCK_BYTES),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (byte_count[ADDR_W-1:0]),
        .wr_data (byte_in),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Block capture FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            block_ready <= 1'b0;
            crc_ok      <= 1'b0;
            byte_count  <= '0;
            crc         <= 16'h0000;
            crc_rx_hi   <= 8'h00;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // A byte strobe arriving with start is dropped.
                    if (start) begin
                        state       <= DATA;
                        busy        <= 1'b1;
                        block_ready <= 1'b0;
                        crc_ok      <= 1'b0;
                        byte_count  <= '0;
                        crc         <= 16'h0000;
                    end
                end
                DATA: begin
                    if (byte_valid) begin
                        crc <= crc16_step(crc, byte_in);
                        if (byte_count != FULL_COUNT) begin
                            byte_count <= byte_count + ONE;
                        end
                        if (byte_count == LAST_COUNT) begin
                            state <= CRC_HI;
                        end
                    end
                end
                CRC_HI: begin
                    if (byte_valid) begin
                        crc_rx_hi <= byte_in;
                        state     <= CRC_LO;
                    end
                end
                CRC_LO: begin
                    if (byte_valid) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        block_ready <= 1'b1;
                        crc_ok      <= ({crc_rx_hi, byte_in} == crc);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/sd_block_buffer.md
SD_BLOCK_BUFFER -- requirements
Module: sd_block_buffer

Interface
REQ-001 SHALL have parameter BLOCK_BYTES, default 512, data bytes per block.
REQ-002 SHALL have parameter ADDR_W, default 9, read-address width (clog2 of BLOCK_BYTES).
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse arming capture of a block (issued when the data token 0xFE is seen).
REQ-006 SHALL have port byte_in  input  8  byte received from the SD card controller (incoming_byte).
REQ-007 SHALL have port byte_valid  input  1  one-cycle strobe qualifying byte_in (finished_byte).
REQ-008 SHALL have port rd_addr  input  ADDR_W  consumer read address.
REQ-009 SHALL have port rd_data  output  8  buffered byte at rd_addr, registered.
REQ-010 SHALL have port busy  output  1  high while capturing data or CRC bytes.
REQ-011 SHALL have port block_ready  output  1  high from block completion until next start or rst.
REQ-012 SHALL have port crc_ok  output  1  valid with block_ready; received CRC equals computed CRC.
REQ-013 SHALL have port byte_count  output  ADDR_W+1  data bytes captured so far in current block.

Function
REQ-014 SHALL implement FSM states IDLE, DATA, CRC_HI, CRC_LO, DONE.
REQ-015 IDLE/DONE + start SHALL go to DATA next cycle, clear byte_count, CRC accumulator (to 0x0000), block_ready, crc_ok.
REQ-016 In DATA, each byte_valid SHALL write byte_in to RAM at byte_count, advance CRC, increment byte_count.
REQ-017 DATA SHALL go to CRC_HI on the byte_valid that makes byte_count equal BLOCK_BYTES.
REQ-018 CRC_HI SHALL latch byte_in as received CRC[15:8] on byte_valid, then go to CRC_LO.
REQ-019 CRC_LO SHALL latch byte_in as CRC[7:0] on byte_valid, then go to DONE.
REQ-020 On DONE entry, block_ready SHALL assert and crc_ok SHALL equal (received CRC == computed CRC), same cycle.
REQ-021 CRC SHALL be CRC16-CCITT, poly 0x1021, init 0x0000, MSB-first, no final XOR, over data bytes only.
REQ-022 busy SHALL be high in DATA, CRC_HI, CRC_LO; low in IDLE, DONE.
REQ-023 start while busy SHALL be ignored (no restart, no state change).
REQ-024 byte_valid in IDLE or DONE SHALL be ignored (no RAM write, no count change).
REQ-025 start and byte_valid in same cycle in IDLE/DONE: start taken, byte discarded.
REQ-026 rd_data SHALL equal RAM[rd_addr] one cycle after rd_addr is presented, in any state.
REQ-027 Read of an address being written same cycle SHALL return old data (read-before-write).
REQ-028 byte_count SHALL saturate at BLOCK_BYTES; no wrap to 0 within a block.

Reset
REQ-029 rst SHALL force IDLE, busy=0, block_ready=0, crc_ok=0, byte_count=0, CRC=0x0000, rd_data=0x00.
REQ-030 rst mid-block SHALL abandon capture; RAM contents need not be cleared.
REQ-031 rst SHALL dominate start and byte_valid in the same cycle.

Structure
REQ-032 Shared package sd_pkg SHALL hold CRC16 polynomial, default block size, data-token value 0xFE, FSM state encoding.
REQ-033 RAM SHALL be sub-module sd_block_ram (BLOCK_BYTES x 8, one sync write port, one sync read port).
REQ-034 CRC byte-step SHALL be a function in sd_pkg, not a separate module.

Verification
REQ-035 start, 512 x 0xFF, CRC bytes 0x7F,0xA1 -> block_ready=1, crc_ok=1, byte_count=512, every rd_data=0xFF.
REQ-036 Same block with CRC 0x7F,0xA0 -> block_ready=1, crc_ok=0.
REQ-037 start, bytes i&0xFF for i=0..511 -> rd_addr=5 gives rd_data=0x05 one cycle later; rd_addr=300 gives 0x2C.
REQ-038 rst after 100 data bytes -> IDLE, busy=0, byte_count=0; next start + full block completes with correct crc_ok.
REQ-039 start asserted at byte 10 of a block -> ignored; block completes after 512+2 strobes; stray byte_valid in DONE leaves RAM unchanged.
